spi_lcd_rx: RTL and testbench
=============================

Name: spi_lcd_rx

Overview:
- Display-side SPI receiver and command decoder: the responder for our SPI display command/data stream (MOSI, DC, CS, SCK).
- Deserialises bytes and decodes SET_COLUMN (0x2A), SET_PAGE (0x2B) and WRITE_RAM (0x2C).
- Turns RAM data into addressed RGB565 pixel writes for a frame-buffer model or a bench scoreboard.
- Sits on the far side of the panel interface and checks the clear/draw drivers end-to-end.

Parameters:
- WIDTH, 240, panel columns; reset value of column end is WIDTH-1.
- HEIGHT, 320, panel rows; reset value of page end is HEIGHT-1.
- SET_COLUMN, 8'h2A, column-address command.
- SET_PAGE, 8'h2B, page-address command.
- WRITE_RAM, 8'h2C, memory-write command.

Ports:
- i_clk  in  1  system clock; must be at least 4x the SCK frequency.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sck  in  1  SPI clock (mode 0), asynchronous to i_clk.
- i_mosi  in  1  serial data, MSB first.
- i_dc  in  1  0 = command byte, 1 = data byte.
- i_cs  in  1  active-low chip select.
- o_byte_valid  out  1  one-cycle pulse when a byte completes.
- o_byte  out  8  received byte; held until the next byte.
- o_byte_dc  out  1  DC value latched with o_byte.
- o_pix_valid  out  1  one-cycle pixel-write pulse.
- o_pix_x  out  9  pixel column.
- o_pix_y  out  9  pixel row.
- o_pix_data  out  16  RGB565 pixel, high byte received first.
- o_oob  out  1  one-cycle pulse when a pixel is dropped for being out of range.

Behaviour:
- Reset:
  - All outputs 0.
  - xs=0, xe=WIDTH-1, ys=0, ye=HEIGHT-1.
  - FSM in IDLE; bit counter 0.
- Input sync: i_sck, i_mosi, i_dc, i_cs each pass through a 2-FF synchroniser. The SCK rise is detected on the synchronised signal (sck_q1 & ~sck_q2).
- Shifting: on a detected SCK rise with synchronised CS low, shift MOSI into bit 0 and increment the 3-bit bit counter.
- Byte completion:
  - On the 8th rise, the byte and the synchronised DC are captured.
  - o_byte_valid pulses on the next i_clk.
  - Counter wraps to 0.
- CS high (synchronised): bit counter clears immediately and any partial byte is discarded. FSM state and address registers are kept.
- Decode FSM, advanced only on o_byte_valid:
  - Any command byte (dc=0) in any state: go to CASET if 0x2A, PASET if 0x2B, RAMWR if 0x2C, else IGNORE. Clear the data-byte index (0..3) and the pixel-half flag.
  - CASET / PASET data bytes:
    - Fill a 32-bit shadow in order start_hi, start_lo, end_hi, end_lo.
    - On the 4th byte, commit xs/xe (or ys/ye) together.
    - Bytes beyond the 4th are ignored.
    - A command arriving before the 4th byte discards the shadow; no partial commit.
  - RAMWR:
    - Entry loads the pointer px=xs, py=ys.
    - Data bytes alternate high/low.
    - On the low byte, o_pix_valid pulses on the next cycle with o_pix_data={hi,lo}, o_pix_x=px[8:0], o_pix_y=py[8:0].
    - Then the pointer advances:
      - if px==xe: px=xs, and py = (py==ye) ? ys : py+1;
      - else px=px+1.
    - A dangling high byte at command change is discarded.
  - IGNORE: data bytes produce o_byte_valid only.
  - IDLE: data bytes produce o_byte_valid only.
- Address arithmetic: 16-bit unsigned. Out of range means px>=WIDTH or py>=HEIGHT. In that case o_pix_valid stays low, o_oob pulses instead, and the pointer still advances.
- Degenerate window: xs>xe (or ys>ye) is accepted as written. The wrap compare is equality only, so the pointer increments until it wraps through 16 bits. o_oob flags those pixels.
- Latency: 8th SCK rise at the pin → o_byte_valid 3–4 i_clk later → o_pix_valid exactly 1 i_clk after the low byte's o_byte_valid.
- Asynchronous reset mid-transfer clears everything immediately. The first byte after release needs a full 8 bits with CS low.

Test Plan:
- Reset defaults: issue 2C, then data 0xF8,0x00 → o_pix_valid once with x=0, y=0, data=16'hF800.
- Clear-band sequence:
  - Stimulus: 2A {00 00 00 EF}, 2B {00 00 00 07}, 2C + 3840 bytes of 0x00.
  - Required: exactly 1920 o_pix_valid pulses, raster order.
  - First pulse (0,0); pulse 240 is (239,0); last is (239,7); no o_oob.
- Window wrap:
  - Stimulus: 2A {00 0A 00 0B}, 2B {00 05 00 06}, 2C + 5 pixels.
  - Required: coordinates (10,5), (11,5), (10,6), (11,6), (10,5).
- Aborts:
  - Stimulus: CS raised after 5 bits of a byte, then a clean 0x2A followed by only 2 data bytes, then 0x2C.
  - Required: partial byte never reported; xs/xe unchanged; first pixel at the old xs.
- Unknown command and out of range:
  - Stimulus: 0x36 + data 0x48, then 2A {01 00 01 01} and 2C + 1 pixel.
  - Required: 0x36 changes no register; the pixel at x=256 gives o_oob=1 with o_pix_valid=0.
- Reset mid-RAMWR: assert i_rst_n=0 after 3 pixels → all outputs 0 asynchronously; after release, 2C + 1 pixel lands at (0,0).

Source files
------------

// File: rtl/spi_lcd_rx.sv
// spi_lcd_rx: display-side SPI (mode 0) receiver and command decoder.
// Deserialises MOSI bytes, decodes SET_COLUMN / SET_PAGE / WRITE_RAM and
// converts WRITE_RAM data into addressed RGB565 pixel writes.
//
// Ports:
//   i_clk, i_rst_n      system clock (>= 4x SCK), async active-low reset
//   i_sck, i_mosi       SPI clock and data (MSB first), async to i_clk
//   i_dc, i_cs          0 = command / 1 = data; active-low chip select
//   o_byte_valid        one-cycle pulse per completed byte
//   o_byte, o_byte_dc   last received byte and its DC value (held)
//   o_pix_valid         one-cycle in-range pixel write pulse
//   o_pix_x, o_pix_y    pixel column / row
//   o_pix_data          RGB565 pixel, high byte first on the wire
//   o_oob               one-cycle pulse for a dropped out-of-range pixel
//
// Decode states:
//   state  | meaning
//   IDLE   | no command seen since reset; data bytes ignored
//   CASET  | collecting column start/end bytes
//   PASET  | collecting page start/end bytes
//   RAMWR  | pairing data bytes into pixels at the window pointer
//   IGNORE | unknown command; data bytes ignored
module spi_lcd_rx #(
  parameter int         WIDTH      = 240,
  parameter int         HEIGHT     = 320,
  parameter logic [7:0] SET_COLUMN = 8'h2A,
  parameter logic [7:0] SET_PAGE   = 8'h2B,
  parameter logic [7:0] WRITE_RAM  = 8'h2C
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sck,
  input  logic        i_mosi,
  input  logic        i_dc,
  input  logic        i_cs,
  output logic        o_byte_valid,
  output logic [7:0]  o_byte,
  output logic        o_byte_dc,
  output logic        o_pix_valid,
  output logic [8:0]  o_pix_x,
  output logic [8:0]  o_pix_y,
  output logic [15:0] o_pix_data,
  output logic        o_oob
);

  localparam logic [15:0] W16 = 16'(WIDTH);
  localparam logic [15:0] H16 = 16'(HEIGHT);

  typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, IGNORE} state_t;

  // ---------------- input synchronisers ----------------
  logic sck_m_q, sck_q1, sck_q2;
  logic mosi_m_q, mosi_q1;
  logic dc_m_q, dc_q1;
  logic cs_m_q, cs_q1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sck_m_q  <= 1'b0;
      sck_q1   <= 1'b0;
      sck_q2   <= 1'b0;
      mosi_m_q <= 1'b0;
      mosi_q1  <= 1'b0;
      dc_m_q   <= 1'b0;
      dc_q1    <= 1'b0;
      cs_m_q   <= 1'b1;
      cs_q1    <= 1'b1;
    end else begin
      sck_m_q  <= i_sck;
      sck_q1   <= sck_m_q;
      sck_q2   <= sck_q1;
      mosi_m_q <= i_mosi;
      mosi_q1  <= mosi_m_q;
      dc_m_q   <= i_dc;
      dc_q1    <= dc_m_q;
      cs_m_q   <= i_cs;
      cs_q1    <= cs_m_q;
    end
  end

  logic sck_rise;
  assign sck_rise = sck_q1 & ~sck_q2;

  // ---------------- deserialiser ----------------
  logic [6:0] shift_q;
  logic [2:0] bitcnt_q;
  logic       cap_valid_q;
  logic [7:0] cap_byte_q;
  logic       cap_dc_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q     <= '0;
      bitcnt_q    <= '0;
      cap_valid_q <= 1'b0;
      cap_byte_q  <= '0;
      cap_dc_q    <= 1'b0;
    end else begin
      cap_valid_q <= 1'b0;
      if (cs_q1) begin
        // deselect drops any partial byte; only the bit count matters
        bitcnt_q <= '0;
      end else if (sck_rise) begin
        shift_q  <= {shift_q[5:0], mosi_q1};
        bitcnt_q <= bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          cap_valid_q <= 1'b1;
          cap_byte_q  <= {shift_q, mosi_q1};
          cap_dc_q    <= dc_q1;
        end
      end
    end
  end

  logic       byte_valid_q;
  logic [7:0] byte_q;
  logic       byte_dc_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      byte_dc_q    <= 1'b0;
    end else begin
      byte_valid_q <= cap_valid_q;
      if (cap_valid_q) begin
        byte_q    <= cap_byte_q;
        byte_dc_q <= cap_dc_q;
      end
    end
  end

  // ---------------- decode FSM ----------------
  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;       // data-byte index, saturates at 4
  logic        half_q, half_d;     // high byte of a pixel is pending
  logic [7:0]  hi_q, hi_d;
  logic [23:0] shadow_q, shadow_d; // first three address bytes
  logic [15:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [15:0] px_q, px_d, py_q, py_d;
  logic        pix_valid_q, pix_valid_d;
  logic        oob_q, oob_d;
  logic [8:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0] pix_data_q, pix_data_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      half_q      <= 1'b0;
      hi_q        <= '0;
      shadow_q    <= '0;
      xs_q        <= '0;
      xe_q        <= W16 - 16'd1;
      ys_q        <= '0;
      ye_q        <= H16 - 16'd1;
      px_q        <= '0;
      py_q        <= '0;
      pix_valid_q <= 1'b0;
      oob_q       <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      half_q      <= half_d;
      hi_q        <= hi_d;
      shadow_q    <= shadow_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ys_q        <= ys_d;
      ye_q        <= ye_d;
      px_q        <= px_d;
      py_q        <= py_d;
      pix_valid_q <= pix_valid_d;
      oob_q       <= oob_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_data_q  <= pix_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    half_d      = half_q;
    hi_d        = hi_q;
    shadow_d    = shadow_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    px_d        = px_q;
    py_d        = py_q;
    pix_valid_d = 1'b0;
    oob_d       = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_data_d  = pix_data_q;

    if (byte_valid_q) begin
      if (!byte_dc_q) begin
        idx_d  = '0;
        half_d = 1'b0;
        if (byte_q == SET_COLUMN) begin
          state_d = CASET;
        end else if (byte_q == SET_PAGE) begin
          state_d = PASET;
        end else if (byte_q == WRITE_RAM) begin
          state_d = RAMWR;
          px_d    = xs_q;
          py_d    = ys_q;
        end else begin
          state_d = IGNORE;
        end
      end else begin
        case (state_q)
          CASET, PASET: begin
            if (idx_q < 3'd4) begin
              idx_d    = idx_q + 3'd1;
              shadow_d = {shadow_q[15:0], byte_q};
              if (idx_q == 3'd3) begin
                if (state_q == CASET) begin
                  xs_d = shadow_q[23:8];
                  xe_d = {shadow_q[7:0], byte_q};
                end else begin
                  ys_d = shadow_q[23:8];
                  ye_d = {shadow_q[7:0], byte_q};
                end
              end
            end
          end
          RAMWR: begin
            if (!half_q) begin
              hi_d   = byte_q;
              half_d = 1'b1;
            end else begin
              half_d = 1'b0;
              if (px_q < W16 && py_q < H16) begin
                pix_valid_d = 1'b1;
                pix_x_d     = px_q[8:0];
                pix_y_d     = py_q[8:0];
                pix_data_d  = {hi_q, byte_q};
              end else begin
                oob_d = 1'b1;
              end
              // equality-only wrap: a degenerate window runs through 16 bits
              if (px_q == xe_q) begin
                px_d = xs_q;
                py_d = (py_q == ye_q) ? ys_q : py_q + 16'd1;
              end else begin
                px_d = px_q + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_byte_valid = byte_valid_q;
  assign o_byte       = byte_q;
  assign o_byte_dc    = byte_dc_q;
  assign o_pix_valid  = pix_valid_q;
  assign o_pix_x      = pix_x_q;
  assign o_pix_y      = pix_y_q;
  assign o_pix_data   = pix_data_q;
  assign o_oob        = oob_q;

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Testbench for spi_lcd_rx: drives SPI mode-0 traffic and compares received
// bytes and pixel events against a byte-level reference model of the panel.
module tb_spi_lcd_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0, mosi = 1'b0, dc = 1'b0, cs = 1'b1;
  logic        o_byte_valid, o_byte_dc, o_pix_valid, o_oob;
  logic [7:0]  o_byte;
  logic [8:0]  o_pix_x, o_pix_y;
  logic [15:0] o_pix_data;

  spi_lcd_rx dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sck(sck), .i_mosi(mosi), .i_dc(dc),
    .i_cs(cs), .o_byte_valid(o_byte_valid), .o_byte(o_byte),
    .o_byte_dc(o_byte_dc), .o_pix_valid(o_pix_valid), .o_pix_x(o_pix_x),
    .o_pix_y(o_pix_y), .o_pix_data(o_pix_data), .o_oob(o_oob)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          pv;
    bit          oob;
    int          x;
    int          y;
    logic [15:0] d;
  } pix_t;

  pix_t       got_pix[$], exp_pix[$];
  logic [8:0] got_b[$], exp_b[$];

  int passes = 0;
  int total  = 0;

  // reference model state
  int          m_mode;       // 0 none/ignore, 1 column, 2 page, 3 ram write
  int          m_args[$];
  int          m_xs, m_xe, m_ys, m_ye, m_px, m_py;
  bit          m_have_hi;
  logic [7:0]  m_hi;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_pix_valid || o_oob)
        got_pix.push_back('{pv: o_pix_valid, oob: o_oob, x: int'(o_pix_x),
                            y: int'(o_pix_y), d: o_pix_data});
      if (o_byte_valid) got_b.push_back({o_byte_dc, o_byte});
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_mode = 0; m_args.delete(); m_have_hi = 0; m_hi = 0;
    m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319; m_px = 0; m_py = 0;
  endtask

  task automatic model_byte(input bit bdc, input logic [7:0] b);
    exp_b.push_back({bdc, b});
    if (!bdc) begin
      m_args.delete();
      m_have_hi = 0;
      case (b)
        8'h2A: m_mode = 1;
        8'h2B: m_mode = 2;
        8'h2C: begin m_mode = 3; m_px = m_xs; m_py = m_ys; end
        default: m_mode = 0;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      if (m_args.size() < 4) begin
        m_args.push_back(int'(b));
        if (m_args.size() == 4) begin
          if (m_mode == 1) begin
            m_xs = m_args[0] * 256 + m_args[1]; m_xe = m_args[2] * 256 + m_args[3];
          end else begin
            m_ys = m_args[0] * 256 + m_args[1]; m_ye = m_args[2] * 256 + m_args[3];
          end
        end
      end
    end else if (m_mode == 3) begin
      if (!m_have_hi) begin
        m_hi = b; m_have_hi = 1;
      end else begin
        bit o;
        m_have_hi = 0;
        o = (m_px >= 240) || (m_py >= 320);
        exp_pix.push_back('{pv: !o, oob: o, x: m_px, y: m_py, d: {m_hi, b}});
        if (m_px == m_xe) begin
          m_px = m_xs;
          m_py = (m_py == m_ye) ? m_ys : (m_py + 1) % 65536;
        end else begin
          m_px = (m_px + 1) % 65536;
        end
      end
    end
  endtask

  task automatic send_bits(input bit bdc, input logic [7:0] b, input int n);
    cs = 1'b0;
    dc = bdc;
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      #20 sck = 1'b1;
      #20 sck = 1'b0;
    end
  endtask

  task automatic send(input bit bdc, input logic [7:0] b);
    send_bits(bdc, b, 8);
    model_byte(bdc, b);
  endtask

  task automatic set_win(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e);
    send(0, cmd);
    send(1, s[15:8]); send(1, s[7:0]);
    send(1, e[15:8]); send(1, e[7:0]);
  endtask

  task automatic send_pix(input logic [15:0] d);
    send(1, d[15:8]);
    send(1, d[7:0]);
  endtask

  task automatic settle();
    #200;
    cs = 1'b1;
    #40;
  endtask

  task automatic compare_logs(input string tag);
    int n;
    check({tag, "_npix"}, 64'(got_pix.size()), 64'(exp_pix.size()));
    n = (got_pix.size() < exp_pix.size()) ? got_pix.size() : exp_pix.size();
    for (int i = 0; i < n; i++) begin
      if (exp_pix[i].oob)
        check({tag, "_oob"}, {62'd0, got_pix[i].pv, got_pix[i].oob}, 64'd1);
      else
        check({tag, "_pix"},
              {got_pix[i].pv, got_pix[i].oob, 9'(got_pix[i].x), 9'(got_pix[i].y), got_pix[i].d},
              {1'b1, 1'b0, 9'(exp_pix[i].x), 9'(exp_pix[i].y), exp_pix[i].d});
    end
    check({tag, "_nbyte"}, 64'(got_b.size()), 64'(exp_b.size()));
    n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int i = 0; i < n; i++) check({tag, "_byte"}, 64'(got_b[i]), 64'(exp_b[i]));
    got_pix.delete(); exp_pix.delete(); got_b.delete(); exp_b.delete();
  endtask

  task automatic check_xy(input string tag, input int idx, input int x, input int y);
    if (idx < got_pix.size())
      check(tag, {32'(got_pix[idx].x), 32'(got_pix[idx].y)}, {32'(x), 32'(y)});
    else
      check({tag, "_missing"}, 64'(got_pix.size()), 64'(idx + 1));
  endtask

  function automatic logic [63:0] all_outs();
    return {18'd0, o_byte_valid, o_byte, o_byte_dc, o_pix_valid, o_pix_x, o_pix_y,
            o_pix_data, o_oob};
  endfunction

  initial begin
    int wx[5], wy[5];
    wx = '{10, 11, 10, 11, 10};
    wy = '{5, 5, 6, 6, 5};
    model_reset();

    // reset state
    #33;
    check("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    #40;
    check("idle_outs", all_outs(), 64'd0);

    // reset-default window
    send(0, 8'h2C);
    send_pix(16'hF800);
    settle();
    check_xy("default_xy", 0, 0, 0);
    if (got_pix.size() > 0) check("default_data", 64'(got_pix[0].d), 64'hF800);
    compare_logs("default");

    // clear band, two rows
    set_win(8'h2A, 16'd0, 16'd239);
    set_win(8'h2B, 16'd0, 16'd1);
    send(0, 8'h2C);
    for (int i = 0; i < 480; i++) send_pix(16'h0000);
    settle();
    check("band_count", 64'(got_pix.size()), 64'd480);
    check_xy("band_first", 0, 0, 0);
    check_xy("band_240", 239, 239, 0);
    check_xy("band_last", 479, 239, 1);
    compare_logs("band");

    // window wrap
    set_win(8'h2A, 16'd10, 16'd11);
    set_win(8'h2B, 16'd5, 16'd6);
    send(0, 8'h2C);
    for (int i = 0; i < 5; i++) send_pix(16'($urandom));
    settle();
    for (int i = 0; i < 5; i++) check_xy("wrap_xy", i, wx[i], wy[i]);
    compare_logs("wrap");

    // aborted byte and truncated column command
    send_bits(0, 8'h2B, 5);
    #20 cs = 1'b1;
    #60;
    send(0, 8'h2A);
    send(1, 8'h00); send(1, 8'h50);
    send(0, 8'h2C);
    send_pix(16'($urandom));
    settle();
    check_xy("abort_xy", 0, 10, 5);
    compare_logs("abort");

    // unknown command, then out-of-range column
    send(0, 8'h36); send(1, 8'h48);
    send(0, 8'h2C); send_pix(16'h1234);
    set_win(8'h2A, 16'h0100, 16'h0101);
    send(0, 8'h2C); send_pix(16'hABCD);
    settle();
    check_xy("unk_xy", 0, 10, 5);
    if (got_pix.size() > 1) check("oob_flags", {62'd0, got_pix[1].pv, got_pix[1].oob}, 64'd1);
    compare_logs("unk");

    // randomized windows
    for (int r = 0; r < 4; r++) begin
      int xs, ys;
      xs = $urandom_range(0, 250);
      ys = $urandom_range(0, 318);
      set_win(8'h2A, 16'(xs), 16'(xs + $urandom_range(0, 3)));
      set_win(8'h2B, 16'(ys), 16'(ys + $urandom_range(0, 2)));
      send(0, 8'h2C);
      for (int i = $urandom_range(3, 8); i > 0; i--) send_pix(16'($urandom));
      settle();
      compare_logs("rand");
    end

    // asynchronous reset mid-RAMWR
    set_win(8'h2A, 16'd3, 16'd5);
    set_win(8'h2B, 16'd2, 16'd2);
    send(0, 8'h2C);
    for (int i = 0; i < 3; i++) send_pix(16'($urandom) | 16'h0101);
    send(1, 8'hA5);
    #200;
    compare_logs("pre_rst");
    rst_n = 1'b0;
    cs = 1'b1;
    #1;
    check("rst_async", all_outs(), 64'd0);
    model_reset();
    #9;
    rst_n = 1'b1;
    #40;
    send(0, 8'h2C);
    send_pix(16'h07E0);
    settle();
    check_xy("post_rst_xy", 0, 0, 0);
    compare_logs("post_rst");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
